// File: rtl/set_assoc_cache_if.sv
// Bus bundle for set_assoc_cache: core request/response and word-wide memory port.
// The cache attaches through the slave modport; the core/memory side uses master.
interface set_assoc_cache_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [31:0] req_wdata;
   logic [3:0]  req_strb;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   // A transfer completes on a rising edge with valid & ready both high; the valid side
   // holds its payload stable until then, and ready is ignored while valid is low.
   modport master (
      output req_valid, req_addr, req_we, req_wdata, req_strb, mem_ready, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, mem_valid, mem_we, mem_addr, mem_wdata
   );
   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, req_strb, mem_ready, mem_rdata,
      output req_ready, resp_valid, resp_rdata, mem_valid, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with tree pseudo-LRU replacement
// and a controller that writes back dirty victims and refills lines one word at a time.
module set_assoc_cache #(
   parameter int NUM_WAYS   = 2,
   parameter int LINE_SIZE  = 16,
   parameter int CACHE_SIZE = 1024
) (
   input  logic             clk,
   input  logic             rst,
   set_assoc_cache_if.slave bus,
   output logic [2:0]       dbg_state
);
   localparam int SETS  = CACHE_SIZE / (LINE_SIZE * NUM_WAYS);
   localparam int WORDS = LINE_SIZE / 4;
   localparam int OFF_W = $clog2(LINE_SIZE);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 32 - OFF_W - IDX_W;
   localparam int LVL   = $clog2(NUM_WAYS);
   localparam int IW    = (IDX_W > 0) ? IDX_W : 1;
   localparam int CW    = (OFF_W > 2) ? OFF_W - 2 : 1;
   localparam int WW    = (LVL > 0) ? LVL : 1;
   localparam int LW    = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, REREAD} state_t;
   state_t state, state_nxt;

   logic [TAG_W-1:0]    tag_arr   [NUM_WAYS][SETS];
   logic [31:0]         data_arr  [NUM_WAYS][SETS][WORDS];
   logic [NUM_WAYS-1:0] valid_arr [SETS];
   logic [NUM_WAYS-1:0] dirty_arr [SETS];
   logic [LW-1:0]       plru_arr  [SETS];

   logic [TAG_W-1:0] tag_q, victim_tag_q;
   logic [IW-1:0]    idx_q, rd_idx;
   logic [CW-1:0]    word_q, rd_word, cnt_q;
   logic             we_q;
   logic [31:0]      wdata_q;
   logic [3:0]       strb_q;
   logic [TAG_W-1:0] rd_tag_q  [NUM_WAYS];
   logic [31:0]      rd_word_q [NUM_WAYS];
   logic [WW-1:0]    victim_q, victim, hit_way;
   logic             hit, accept, mem_done, last_word;
   logic [LW-1:0]    plru_upd;
   logic [31:0]      merged, resp_rdata_q, mem_wdata_q;
   logic             resp_valid_q;
   logic             mem_valid_c, mem_we_c;
   logic [31:0]      mem_addr_c;

   function automatic logic [31:0] word_addr(input logic [TAG_W-1:0] t, input logic [IW-1:0] i,
                                             input logic [CW-1:0] c);
      word_addr = (32'(t) << (OFF_W + IDX_W)) | (32'(i) << OFF_W) | (32'(c) << 2);
   endfunction

   assign bus.req_ready  = (state == IDLE) && !rst;
   assign accept         = bus.req_valid && bus.req_ready;
   assign mem_done       = bus.mem_valid && bus.mem_ready;
   assign last_word      = (cnt_q == CW'(WORDS - 1));
   assign rd_idx         = accept ? IW'((bus.req_addr >> OFF_W) & 32'(SETS - 1)) : idx_q;
   assign rd_word        = accept ? CW'((bus.req_addr >> 2) & 32'(WORDS - 1)) : word_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_valid  = mem_valid_c;
   assign bus.mem_we     = mem_we_c;
   assign bus.mem_addr   = mem_addr_c;
   assign bus.mem_wdata  = mem_wdata_q;
   assign dbg_state      = state;

   // Tree walk: each node bit points at its less-recently-used subtree (0 = lower half).
   always_comb begin
      logic          found;
      logic [LW-1:0] tree, sh;
      int            node, pw, dir;
      hit = 1'b0; hit_way = '0; victim = '0; found = 1'b0;
      sh = '0; dir = 0; node = 0; pw = 0; merged = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!hit && valid_arr[idx_q][w] && rd_tag_q[w] == tag_q) begin
            hit = 1'b1; hit_way = WW'(w);
         end
         if (!found && !valid_arr[idx_q][w]) begin
            found = 1'b1; victim = WW'(w);
         end
      end
      tree = plru_arr[idx_q];
      for (int l = 0; l < LVL; l++) begin
         sh = tree >> node;
         dir = int'(sh[0]);
         pw = pw * 2 + dir;
         node = 2 * node + 1 + dir;
      end
      if (!found) victim = WW'(pw);
      plru_upd = tree;
      for (int l = 0; l < LVL; l++) begin
         node = (1 << l) - 1 + (int'(hit_way) >> (LVL - l));
         if (((int'(hit_way) >> (LVL - 1 - l)) & 1) == 1) plru_upd = plru_upd & ~(LW'(1) << node);
         else                                              plru_upd = plru_upd | (LW'(1) << node);
      end
      for (int b = 0; b < 4; b++)
         merged[8*b +: 8] = strb_q[b] ? wdata_q[8*b +: 8] : rd_word_q[hit_way][8*b +: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      mem_valid_c = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      case (state)
         IDLE:   if (accept) state_nxt = LOOKUP;
         LOOKUP: begin
            if (hit)                                                         state_nxt = IDLE;
            else if (valid_arr[idx_q][victim] && dirty_arr[idx_q][victim]) state_nxt = WRITEBACK;
            else                                                             state_nxt = REFILL;
         end
         WRITEBACK: begin
            mem_valid_c = 1'b1;
            mem_we_c    = 1'b1;
            mem_addr_c  = word_addr(victim_tag_q, idx_q, cnt_q);
            if (bus.mem_ready && last_word) state_nxt = REFILL;
         end
         REFILL: begin
            mem_valid_c = 1'b1;
            mem_addr_c  = word_addr(tag_q, idx_q, cnt_q);
            if (bus.mem_ready && last_word) state_nxt = REREAD;
         end
         REREAD:  state_nxt = LOOKUP;
         default: state_nxt = IDLE;
      endcase
   end

   // Tag/data storage carries no reset; lines are only trusted through valid_arr.
   always_ff @(posedge clk) begin
      if (state == LOOKUP && hit && we_q) data_arr[hit_way][idx_q][word_q] <= merged;
      if (state == REFILL && mem_done) begin
         data_arr[victim_q][idx_q][cnt_q] <= bus.mem_rdata;
         if (last_word) tag_arr[victim_q][idx_q] <= tag_q;
      end
      if (accept || state == REREAD) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            rd_tag_q[w]  <= tag_arr[w][rd_idx];
            rd_word_q[w] <= data_arr[w][rd_idx][rd_word];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_arr[s] <= '0;
            dirty_arr[s] <= '0;
            plru_arr[s]  <= '0;
         end
         tag_q <= '0; idx_q <= '0; word_q <= '0; we_q <= 1'b0; wdata_q <= '0; strb_q <= '0;
         victim_q <= '0; victim_tag_q <= '0; cnt_q <= '0;
         resp_valid_q <= 1'b0; resp_rdata_q <= '0; mem_wdata_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         if (accept) begin
            tag_q   <= TAG_W'(bus.req_addr >> (OFF_W + IDX_W));
            idx_q   <= rd_idx;
            word_q  <= rd_word;
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
            strb_q  <= bus.req_strb;
         end
         case (state)
            LOOKUP: begin
               if (hit) begin
                  resp_valid_q    <= 1'b1;
                  resp_rdata_q    <= we_q ? merged : rd_word_q[hit_way];
                  plru_arr[idx_q] <= plru_upd;
                  if (we_q) dirty_arr[idx_q][hit_way] <= 1'b1;
               end else begin
                  victim_q     <= victim;
                  victim_tag_q <= rd_tag_q[victim];
                  cnt_q        <= '0;
                  mem_wdata_q  <= data_arr[victim][idx_q][0];
               end
            end
            WRITEBACK: if (mem_done) begin
               if (last_word) begin
                  cnt_q <= '0;
                  dirty_arr[idx_q][victim_q] <= 1'b0;
               end else begin
                  cnt_q       <= CW'(cnt_q + 1'b1);
                  mem_wdata_q <= data_arr[victim_q][idx_q][CW'(cnt_q + 1'b1)];
               end
            end
            REFILL: if (mem_done) begin
               if (last_word) begin
                  cnt_q <= '0;
                  valid_arr[idx_q][victim_q] <= 1'b1;
                  dirty_arr[idx_q][victim_q] <= 1'b0;
               end else begin
                  cnt_q <= CW'(cnt_q + 1'b1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache (default parameters: 2 ways, 32 sets, 4 words/line)
// against a word memory model where unwritten mem[A] = A ^ 32'hA5A5A5A5.
module tb_set_assoc_cache;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;
   logic       mem_stall;
   int         vectors = 0;
   int         miscompares = 0;

   logic [31:0] mem_w [logic [31:0]];
   logic [31:0] log_addr [$];
   logic        log_we   [$];
   logic [31:0] log_data [$];

   set_assoc_cache_if bus ();

   set_assoc_cache dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_w.exists(a)) return mem_w[a];
      return a ^ 32'hA5A5A5A5;
   endfunction

   // Memory responder: decides ready mid-cycle and logs each transfer it grants.
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst && bus.mem_valid && !mem_stall) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mem_read(bus.mem_addr);
            log_addr.push_back(bus.mem_addr);
            log_we.push_back(bus.mem_we);
            log_data.push_back(bus.mem_we ? bus.mem_wdata : bus.mem_rdata);
            if (bus.mem_we) mem_w[bus.mem_addr] = bus.mem_wdata;
         end else begin
            bus.mem_ready = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic log_clear();
      log_addr.delete();
      log_we.delete();
      log_data.delete();
   endtask

   task automatic issue_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb);
      int n;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_strb  = strb;
      n = 0;
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("accept", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_resp(output logic [31:0] rd, output int lat);
      lat = 1;
      while (!bus.resp_valid && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check("resp_seen", 32'(bus.resp_valid), 32'd1);
      rd = bus.resp_rdata;
      @(negedge clk);
      check("resp_pulse", 32'(bus.resp_valid), 32'd0);
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output logic [31:0] rd, output int lat);
      issue_req(we, addr, wdata, strb);
      wait_resp(rd, lat);
   endtask

   task automatic check_line_reads(input string tag, input logic [31:0] base);
      check({tag, "_count"}, 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_addr"}, log_addr[i], base + 32'(4 * i));
         check({tag, "_we"}, 32'(log_we[i]), 32'd0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd;
      int          lat;
      int          n;
      logic [31:0] wb_exp [4];
      wb_exp[0] = 32'hA5A5B7A5; wb_exp[1] = 32'h12345678;
      wb_exp[2] = 32'hA5A5B7AD; wb_exp[3] = 32'hA5A5B7A9;
      rst = 1'b1; mem_stall = 1'b0;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_we = 1'b0;
      bus.req_wdata = '0; bus.req_strb = '0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.req_ready), 32'd1);

      // Cold miss then hit in the same line.
      log_clear();
      do_req(1'b0, 32'h0000_1004, '0, '0, rd, lat);
      check("t1_miss_rdata", rd, 32'hA5A5B5A1);
      check_line_reads("t1_refill", 32'h0000_1000);
      log_clear();
      do_req(1'b0, 32'h0000_1008, '0, '0, rd, lat);
      check("t1_hit_lat", 32'(lat), 32'd2);
      check("t1_hit_nomem", 32'(log_addr.size()), 32'd0);
      check("t1_hit_rdata", rd, 32'hA5A5B5AD);

      // Partial store hit, then read back the merged word.
      do_req(1'b1, 32'h0000_1008, 32'hDEADBEEF, 4'b0011, rd, lat);
      check("t2_st_lat", 32'(lat), 32'd2);
      check("t2_st_nomem", 32'(log_addr.size()), 32'd0);
      do_req(1'b0, 32'h0000_1008, '0, '0, rd, lat);
      check("t2_ld_lat", 32'(lat), 32'd2);
      check("t2_ld_rdata", rd, 32'hA5A5BEEF);

      // LRU replacement in set 0 with clean victims.
      do_reset();
      log_clear();
      do_req(1'b0, 32'h0000_1000, '0, '0, rd, lat);
      check("t3_cold_after_rst", 32'(log_addr.size()), 32'd4);
      do_req(1'b0, 32'h0000_1200, '0, '0, rd, lat);
      log_clear();
      do_req(1'b0, 32'h0000_1000, '0, '0, rd, lat);
      check("t3_rehit_lat", 32'(lat), 32'd2);
      check("t3_rehit_rdata", rd, 32'hA5A5B5A5);
      log_clear();
      do_req(1'b0, 32'h0000_1400, '0, '0, rd, lat);
      check_line_reads("t3_evict", 32'h0000_1400);
      check("t3_evict_rdata", rd, 32'hA5A5B1A5);
      log_clear();
      do_req(1'b0, 32'h0000_1000, '0, '0, rd, lat);
      check("t3_keep_hit", 32'(log_addr.size()), 32'd0);
      check("t3_keep_lat", 32'(lat), 32'd2);
      log_clear();
      do_req(1'b0, 32'h0000_1200, '0, '0, rd, lat);
      check_line_reads("t3_gone_miss", 32'h0000_1200);
      check("t3_gone_rdata", rd, 32'hA5A5B7A5);

      // Dirty victim writeback followed by refill.
      do_reset();
      do_req(1'b0, 32'h0000_1200, '0, '0, rd, lat);
      do_req(1'b1, 32'h0000_1204, 32'h12345678, 4'b1111, rd, lat);
      do_req(1'b0, 32'h0000_1000, '0, '0, rd, lat);
      log_clear();
      do_req(1'b0, 32'h0000_1400, '0, '0, rd, lat);
      check("t4_count", 32'(log_addr.size()), 32'd8);
      for (int i = 0; i < 4; i++) begin
         check("t4_wb_addr", log_addr[i], 32'h0000_1200 + 32'(4 * i));
         check("t4_wb_we", 32'(log_we[i]), 32'd1);
         check("t4_wb_data", log_data[i], wb_exp[i]);
         check("t4_rf_addr", log_addr[i+4], 32'h0000_1400 + 32'(4 * i));
         check("t4_rf_we", 32'(log_we[i+4]), 32'd0);
      end
      check("t4_rdata", rd, 32'hA5A5B1A5);
      log_clear();
      do_req(1'b0, 32'h0000_1204, '0, '0, rd, lat);
      check_line_reads("t4_reload", 32'h0000_1200);
      check("t4_reload_rdata", rd, 32'h12345678);

      // Memory stall during refill: request must hold steady.
      mem_stall = 1'b1;
      log_clear();
      issue_req(1'b0, 32'h0000_2010, '0, '0);
      n = 0;
      while (!bus.mem_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check("t5_hold_valid", 32'(bus.mem_valid), 32'd1);
         check("t5_hold_addr", bus.mem_addr, 32'h0000_2010);
         check("t5_hold_we", 32'(bus.mem_we), 32'd0);
         @(negedge clk);
      end
      mem_stall = 1'b0;
      wait_resp(rd, lat);
      check("t5_rdata", rd, 32'hA5A585B5);
      check_line_reads("t5_refill", 32'h0000_2010);

      // Reset in the middle of a refill.
      mem_stall = 1'b1;
      issue_req(1'b0, 32'h0000_3020, '0, '0);
      n = 0;
      while (!bus.mem_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t6_refill_active", 32'(bus.mem_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("t6_mem_valid_drop", 32'(bus.mem_valid), 32'd0);
      check("t6_ready_in_rst", 32'(bus.req_ready), 32'd0);
      check("t6_no_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      mem_stall = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("t6_ready_after", 32'(bus.req_ready), 32'd1);
      check("t6_no_resp_after", 32'(bus.resp_valid), 32'd0);
      log_clear();
      do_req(1'b0, 32'h0000_3020, '0, '0, rd, lat);
      check_line_reads("t6_rerefill", 32'h0000_3020);
      check("t6_rdata", rd, 32'hA5A59585);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
